// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default baud divider.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DATA_BITS       = 8;
  localparam int FRAME_BITS      = 10;
  localparam int CLK_DIV_DEFAULT = 5208;  // 50 MHz / 9600 baud
endpackage

// File: rtl/uart_fifo.sv
// Synchronous byte FIFO with registered full/empty flags derived from the next count.
module uart_fifo import uart_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] dout,
  output logic                 full,
  output logic                 empty
);
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wptr, rptr;
  logic [AW:0]          count, count_nxt;
  logic                 do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (!do_push && do_pop) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage needs no reset: flushed entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter: FIFO-fed FSM with baud counter, shift register and registered tx line.
module uart_sender import uart_pkg::*; #(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int DEPTH   = 4,
  parameter int AW      = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_full,
  output logic                 tx_empty,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [IW-1:0]        idx, idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt, head;
  logic                 pop, tick, done_nxt, tx_nxt;

  uart_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tx_wr),
    .din  (tx_data),
    .pop  (pop),
    .dout (head),
    .full (tx_full),
    .empty(tx_empty)
  );

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    pop       = 1'b0;
    done_nxt  = 1'b0;
    tx_nxt    = 1'b1;
    if (state != IDLE) cnt_nxt = tick ? '0 : cnt + 1'b1;
    case (state)
      IDLE: begin
        if (!tx_empty) begin
          pop       = 1'b1;
          shift_nxt = head;
          cnt_nxt   = '0;
          state_nxt = START;
        end
      end
      START: begin
        tx_nxt = 1'b0;
        if (tick) begin
          state_nxt = DATA;
          idx_nxt   = '0;
        end
      end
      DATA: begin
        tx_nxt = shift[0];
        if (tick) begin
          shift_nxt = {1'b0, shift[DATA_BITS-1:1]};
          idx_nxt   = idx + 1'b1;
          if (idx == IW'(DATA_BITS - 1)) state_nxt = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          done_nxt = 1'b1;
          // Chain straight into the next frame so queued bytes leave with no idle gap.
          if (!tx_empty) begin
            pop       = 1'b1;
            shift_nxt = head;
            state_nxt = START;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // tx follows the current state one cycle later, keeping the line purely registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      shift   <= shift_nxt;
      tx      <= tx_nxt;
      tx_busy <= (state_nxt != IDLE);
      tx_done <= done_nxt;
    end
  end
endmodule

// File: tb/tb_uart_sender.sv
// Directed bench for uart_sender at CLK_DIV=4, DEPTH=4; line decoded cycle by cycle.
module tb_uart_sender;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_full, tx_empty, tx_busy, tx_done, tx;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  uart_sender #(.CLK_DIV(4), .DEPTH(4), .AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_wr   (tx_wr),
    .tx_full (tx_full),
    .tx_empty(tx_empty),
    .tx_busy (tx_busy),
    .tx_done (tx_done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bytes pushed on consecutive cycles, starting at the next edge.
  task automatic write_seq(input logic [7:0] b [], input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_wr   = 1'b1;
      tx_data = b[i];
    end
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  // Waits for a start bit (checking the current sample first), then checks all 40 line cycles.
  task automatic capture(input string tag, input logic [7:0] exp, output int gap);
    logic [9:0] pat;
    logic [7:0] got;
    int errs, dpos;
    pat = {1'b1, exp, 1'b0};
    gap = 0;
    while (tx !== 1'b0 && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    if (gap >= 200) begin
      chk($sformatf("%s_timeout", tag), 32'd0, 32'd1);
      return;
    end
    errs = 0; dpos = -1; got = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      if (tx !== pat[c/4]) errs++;
      if ((c % 4) == 2 && c/4 >= 1 && c/4 <= 8) got[c/4-1] = tx;
      if (tx_done === 1'b1) dpos = c;
    end
    chk($sformatf("%s_byte", tag), 32'(got), 32'(exp));
    chk($sformatf("%s_hold", tag), errs, 0);
    chk($sformatf("%s_done_pos", tag), dpos, 39);
  endtask

  task automatic idle_watch(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  initial begin
    logic [7:0] b [];
    int gap, lows, d0;

    // 1: reset and idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_full", tx_full, 0);
    chk("rst_empty", tx_empty, 1);
    d0 = done_cnt;
    idle_watch(50, lows);
    chk("idle_tx_low", lows, 0);
    chk("idle_done", done_cnt - d0, 0);
    chk("idle_empty", tx_empty, 1);

    // 2: single byte 0xA5, latency and framing
    d0 = done_cnt;
    b = new[1]; b[0] = 8'hA5;
    write_seq(b, 1);
    chk("lat_empty_n", tx_empty, 0);
    chk("lat_tx_n", tx, 1);
    @(negedge clk);
    chk("lat_busy_n1", tx_busy, 1);
    chk("lat_tx_n1", tx, 1);
    capture("a5", 8'hA5, gap);
    chk("a5_lat_gap", gap, 1);
    @(negedge clk);
    chk("a5_busy_after", tx_busy, 0);
    chk("a5_tx_after", tx, 1);
    chk("a5_done_cnt", done_cnt - d0, 1);

    // 3: back-to-back frames
    d0 = done_cnt;
    b = new[3]; b[0] = 8'h00; b[1] = 8'hFF; b[2] = 8'h3C;
    fork
      write_seq(b, 3);
      begin
        capture("b2b0", 8'h00, gap);
        capture("b2b1", 8'hFF, gap);
        chk("b2b1_gap", gap, 1);
        capture("b2b2", 8'h3C, gap);
        chk("b2b2_gap", gap, 1);
      end
    join
    idle_watch(20, lows);
    chk("b2b_tail_idle", lows, 0);
    chk("b2b_done_cnt", done_cnt - d0, 3);
    chk("b2b_busy", tx_busy, 0);

    // 4: overflow drops the sixth byte
    d0 = done_cnt;
    b = new[6]; for (int i = 0; i < 6; i++) b[i] = 8'(i + 1);
    fork
      begin
        write_seq(b, 6);
        chk("ovf_full", tx_full, 1);
      end
      begin
        for (int i = 0; i < 5; i++) capture($sformatf("ovf%0d", i), 8'(i + 1), gap);
      end
    join
    idle_watch(60, lows);
    chk("ovf_no_sixth", lows, 0);
    chk("ovf_done_cnt", done_cnt - d0, 5);
    chk("ovf_empty", tx_empty, 1);

    // 5: write while full on the same edge STOP pops
    d0 = done_cnt;
    b = new[5]; for (int i = 0; i < 5; i++) b[i] = 8'h11 + 8'(i);
    fork
      begin
        write_seq(b, 5);
        repeat (36) @(negedge clk);
        chk("race_full_before", tx_full, 1);
        tx_wr = 1'b1; tx_data = 8'hEE;
        @(negedge clk);
        tx_wr = 1'b0;
        chk("race_full_after", tx_full, 0);
      end
      begin
        for (int i = 0; i < 5; i++) capture($sformatf("race%0d", i), 8'h11 + 8'(i), gap);
      end
    join
    idle_watch(60, lows);
    chk("race_no_extra", lows, 0);
    chk("race_done_cnt", done_cnt - d0, 5);

    // 6: reset mid-frame with bytes queued
    b = new[3]; b[0] = 8'h55; b[1] = 8'h66; b[2] = 8'h77;
    write_seq(b, 3);
    repeat (12) @(negedge clk);
    chk("mid_busy", tx_busy, 1);
    chk("mid_empty", tx_empty, 0);
    rst = 1'b1;
    #1;
    chk("mrst_tx", tx, 1);
    chk("mrst_empty", tx_empty, 1);
    chk("mrst_busy", tx_busy, 0);
    chk("mrst_full", tx_full, 0);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    idle_watch(60, lows);
    chk("mrst_no_frame", lows, 0);
    chk("mrst_done_cnt", done_cnt - d0, 0);
    b = new[1]; b[0] = 8'h3A;
    fork
      write_seq(b, 1);
      capture("post_rst", 8'h3A, gap);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
